mips32_prog_loader: RTL and testbench

- Boot-time instruction loader sitting directly upstream of the MIPS32 pipeline's instruction/data memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into consecutive memory locations from address 0, stopping after the HLT word (0xfc000000).
- Releases the processor (cpu_run) only when a complete program is in memory; this replaces hierarchical MEM preloading by benches.

---
 rtl/mips32_prog_loader.sv | 149 ++++++++++++++
 tb/tb_mips32_prog_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_prog_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes them from address 0 through HLT, then raises cpu_run.
// Build option MIPS32_LOADER_CHECKSUM_EN appends a CHECK state that requires a trailing XOR checksum byte before release.
module mips32_prog_loader #(
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] HLT_WORD = 32'hfc000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              cpu_run,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERR
`ifdef MIPS32_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  // word_count value during the WRITE of the last legal slot
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] word;
  logic [31:0] next_word;
  logic        take;

`ifdef MIPS32_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign next_word = {word[23:0], in_data};
  assign take      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      cpu_run    <= 1'b0;
      err        <= 1'b0;
      byte_cnt   <= '0;
      word       <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          // Re-arming discards any partial word and status from the previous load
          if (start) begin
            state      <= LOAD;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            cpu_run    <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            byte_cnt   <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end

        LOAD: begin
          if (take) begin
            word     <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              state     <= WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= word_count[ADDR_W-1:0];
              mem_wdata <= next_word;
            end
          end
        end

        WRITE: begin
          word_count <= word_count + CNT_ONE;
          if (word == HLT_WORD) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
            state    <= CHECK;
            in_ready <= 1'b1;
`else
            state    <= DONE;
            busy     <= 1'b0;
            cpu_run  <= 1'b1;
`endif
          end else if (word_count == LAST_CNT) begin
            state <= ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end

`ifdef MIPS32_LOADER_CHECKSUM_EN
        CHECK: begin
          if (take) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state   <= DONE;
              cpu_run <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: randomized and directed loads, writes checked by a queue-based scoreboard.
module tb_mips32_prog_loader;

  localparam int          ADDR_W   = 10;
  localparam int          TB_DEPTH = 4;
  localparam logic [31:0] HLT      = 32'hfc000000;

  logic              clk;
  logic              reset;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              cpu_run;
  logic              err;

  mips32_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(TB_DEPTH), .HLT_WORD(HLT)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .busy(busy), .cpu_run(cpu_run), .err(err)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [31:0] prog[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write strobe must match the oldest expected write, land in the
  // cycle right after its 4th byte was accepted, and coincide with in_ready low.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h with no write expected", mem_addr, mem_wdata);
      end else begin
        me = q.pop_front();
        if (32'(mem_addr) != me.addr || mem_wdata != me.data || cyc != me.cyc || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h cyc=%0d in_ready=%b, expected addr=%0d data=%h cyc=%0d in_ready=0",
                   mem_addr, mem_wdata, cyc, in_ready, me.addr, me.data, me.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_word_count"}, 32'(word_count), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_cpu_run"}, 32'(cpu_run), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc, output bit ok);
    bit hs;
    ok = 1'b0;
    acc_cyc = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      hs = in_ready;
      @(posedge clk); #1;
      if (hs) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %h not accepted within 50 cycles", b);
    end
  endtask

  // One full load of 'prog'. The reference outcome comes straight from the loader's
  // rules: words up to and including the first HLT, capped at TB_DEPTH.
  task automatic run_load(input bit bad_csum, input int gapmode, input int abort_after);
    int          n;
    bit          hlt_found;
    bit          exp_done;
    logic [7:0]  b;
    logic [7:0]  csum;
    logic [31:0] w;
    int          k;
    int          acc_cyc;
    int          cnt;
    bit          ok;
    n = 0; hlt_found = 1'b0; csum = 8'h00; k = 0;
    for (int i = 0; i < prog.size(); i++) begin
      n++;
      if (prog[i] == HLT) begin hlt_found = 1'b1; break; end
      if (n == TB_DEPTH) break;
    end

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_cpu_run", 32'(cpu_run), 0);
    check("start_err", 32'(err), 0);
    check("start_word_count", 32'(word_count), 0);

    for (int i = 0; i < n; i++) begin
      w = prog[i];
      for (int j = 0; j < 4; j++) begin
        if (k == abort_after) begin
          reset = 1'b1;
          @(posedge clk); #1;
          check_reset_values("midload_reset");
          check("midload_pending_writes", 32'(q.size()), 0);
          reset = 1'b0;
          return;
        end
        b = w[31-8*j -: 8];
        send_byte(b, pick_gap(gapmode), acc_cyc, ok);
        if (!ok) return;
        csum ^= b;
        k++;
        if (j == 3) q.push_back('{i, w, acc_cyc});
      end
    end

`ifdef MIPS32_LOADER_CHECKSUM_EN
    if (hlt_found) begin
      send_byte(bad_csum ? (csum ^ 8'h01) : csum, pick_gap(gapmode), acc_cyc, ok);
      if (!ok) return;
    end
    exp_done = hlt_found && !bad_csum;
`else
    exp_done = hlt_found;
`endif

    repeat (2) begin @(posedge clk); #1; end
    check("end_cpu_run", 32'(cpu_run), 32'(exp_done));
    check("end_err", 32'(err), 32'(!exp_done));
    check("end_word_count", 32'(word_count), 32'(n));
    check("end_busy", 32'(busy), 0);
    check("end_in_ready", 32'(in_ready), 0);
    check("missing_writes", 32'(q.size()), 0);

    if (!exp_done) begin
      cnt = 0;
      in_valid = 1'b1;
      in_data  = 8'h00;
      repeat (4) begin
        if (in_ready) cnt++;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("err_accepts_bytes", 32'(cnt), 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          len;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed 3-word program, in_valid held high, then toggled
    prog = '{32'h2801000a, 32'h28020014, HLT};
    run_load(1'b0, 0, -1);
    run_load(1'b0, 1, -1);

    // No HLT within DEPTH words: overflow
    prog = '{32'h0, 32'h0, 32'h0, 32'h0};
    run_load(1'b0, 0, -1);

    // Reset after 6 bytes, then a clean reload
    prog = '{32'h2801000a, 32'h28020014, HLT};
    run_load(1'b0, 0, 6);
    run_load(1'b0, 0, -1);

    // Restart from DONE with a HLT-only program
    prog = '{HLT};
    run_load(1'b0, 0, -1);

    // HLT in the very last slot still completes
    prog = '{32'h11111111, 32'h22222222, 32'h33333333, HLT};
    run_load(1'b0, 2, -1);

`ifdef MIPS32_LOADER_CHECKSUM_EN
    prog = '{HLT};
    run_load(1'b0, 0, -1);
    run_load(1'b1, 0, -1);
`endif

    for (int it = 0; it < 10; it++) begin
      prog.delete();
      if ($urandom_range(0, 2) != 0) begin
        len = int'($urandom_range(1, TB_DEPTH));
        for (int i = 0; i < len - 1; i++) begin
          w = $urandom;
          if (w == HLT) w ^= 32'h1;
          prog.push_back(w);
        end
        prog.push_back(HLT);
      end else begin
        for (int i = 0; i < TB_DEPTH; i++) begin
          w = $urandom;
          if (w == HLT) w ^= 32'h1;
          prog.push_back(w);
        end
      end
      run_load(bit'($urandom_range(0, 1)), 2, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
